afifo_write_arbiter: RTL
========================

AFIFO_WRITE_ARBITER -- requirements
Module: afifo_write_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing the FIFO write port.
REQ-002 SHALL have parameter W, default 12: data width of each requester and of the write port.
REQ-003 SHALL have parameter DELAY_W, default 26: width of the startup hold-off counter.
REQ-004 SHALL have port clk  input  1: single clock for all logic; the FIFO write clock.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1: level enable; 0 stops new grants.
REQ-007 SHALL have port req  input  N_REQ: per-requester valid.
REQ-008 SHALL have port data  input  N_REQ*W: packed requester data; requester i occupies bits [i*W +: W].
REQ-009 SHALL have port ack  output  N_REQ: one-hot accept, combinational, same cycle as the grant.
REQ-010 SHALL have port wfull  input  1: FIFO full flag, asserted with at least one entry of slack.
REQ-011 SHALL have port w  output  1: registered FIFO write strobe.
REQ-012 SHALL have port wd  output  W: registered FIFO write data.
REQ-013 SHALL have port wcount  output  16: registered total of completed writes; wraps.

Function
REQ-014 SHALL implement FSM states DELAY, IDLE, RUN, PAUSE.
REQ-015 DELAY: holds off all grants until the hold-off counter reaches all-ones, then goes to IDLE.
REQ-016 IDLE: goes to RUN when en=1.
REQ-017 RUN: goes to PAUSE when en=0.
REQ-018 PAUSE: returns to RUN when en=1. It SHALL NOT re-enter DELAY.
REQ-019 SHALL grant only in RUN with wfull=0, and at most one requester per cycle.
REQ-020 Grant selection SHALL be round-robin. The search starts at the index after the last granted requester and wraps from N_REQ-1 to 0; the pointer SHALL update only on a grant.
REQ-021 ack[i]=1 iff requester i is granted this cycle, which requires req[i]=1. A transfer is the cycle in which req[i]&ack[i].
REQ-022 Latency is one cycle: the cycle after a transfer, w=1 and wd=data of the granted requester; otherwise w=0.
REQ-023 wd SHALL hold its last value when w=0.
REQ-024 wcount SHALL increment by 1 in each cycle with w=1, and wrap 0xFFFF->0.
REQ-025 Full handling: wfull=1 forces ack=0 that cycle. The pointer is unchanged, and w=0 follows.
REQ-026 Simultaneous en falling and a grant: en is sampled combinationally, so en=0 suppresses the grant that same cycle.
REQ-027 A requester dropping req without ack SHALL be legal; no data is lost or duplicated.

Reset
REQ-028 Asserting rst_n=0 at any time, including mid-transfer, SHALL immediately force all of the following:
- ack=0;
- w=0, wd=0, wcount=0;
- round-robin pointer so the next grant searches from index 0;
- hold-off counter=0;
- state=DELAY.
REQ-029 Deassertion of rst_n is synchronized externally; the block SHALL NOT assume any data in flight survived the reset.

Configuration
REQ-030 Macro AFIFO_ARB_STARTUP_DELAY_EN SHALL select the startup hold-off behaviour.
REQ-031 With the macro defined: the DELAY state counts up through 2^DELAY_W-1 cycles before IDLE.
REQ-032 Without the macro: DELAY exits to IDLE on the first clock after reset, and the hold-off counter is not synthesized.

Structure
REQ-033 Package afifo_arb_pkg SHALL hold:
- the state enum (DELAY, IDLE, RUN, PAUSE);
- default constants N_REQ_DEF=4, W_DEF=12, DELAY_W_DEF=26.
REQ-034 Round-robin selection SHALL be the sub-module rr_arbiter, with these ports:
- inputs: req, pointer, enable;
- outputs: one-hot grant, encoded index.
REQ-035 The FSM, output registers and counters SHALL be in afifo_write_arbiter.

Verification
REQ-036 Reset, then en=1, with the macro undefined and DELAY_W=4 -> DELAY exits to IDLE one cycle after reset and RUN is entered on the next cycle. With the macro defined -> the first ack occurs no earlier than 16 cycles after reset.
REQ-037 All four req=1 continuously, data[i]=0x100*i+n -> ack order 0,1,2,3,0,...; wd on w matches the granted data one cycle later; wcount=8 after 8 writes.
REQ-038 req=4'b1010 with wfull pulsed high for 3 cycles -> no ack and w=0 during the pulse; afterwards the grant resumes at the requester after the last granted one, with no data loss.
REQ-039 en dropped for 5 cycles in the same cycle req[2]=1 -> ack[2]=0 that cycle, state PAUSE; on en=1, ack[2] is the next grant.
REQ-040 rst_n=0 asserted in the cycle after a transfer (w pending) -> w=0 and wcount=0 immediately; after release the state is DELAY and the pointer searches from 0.
REQ-041 wcount preloaded near 0xFFFE by 3 writes -> reads 0xFFFF, then 0x0000, then 0x0001.

Source files
------------

// File: rtl/afifo_arb_pkg.sv
// afifo_arb_pkg: shared state encoding and default sizing for the FIFO write arbiter.
package afifo_arb_pkg;
    typedef enum logic [1:0] {DELAY, IDLE, RUN, PAUSE} state_t;
    localparam int N_REQ_DEF   = 4;
    localparam int W_DEF       = 12;
    localparam int DELAY_W_DEF = 26;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; pointer is the first index searched.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] pointer,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);
    logic [IW-1:0] j;
    // Walk the ring backwards so the candidate nearest the pointer is the last one kept.
    always_comb begin
        grant = '0;
        index = '0;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(pointer) + k) % N);
            if (enable && req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                index    = j;
            end
        end
    end
endmodule

// File: rtl/afifo_write_arbiter.sv
// afifo_write_arbiter: round-robin N-to-1 arbiter driving an async FIFO write port.
// Define AFIFO_ARB_STARTUP_DELAY_EN to hold off grants for 2^DELAY_W cycles after reset.
module afifo_write_arbiter
    import afifo_arb_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int W       = W_DEF,
    parameter int DELAY_W = DELAY_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ*W-1:0] data,
    output logic [N_REQ-1:0] ack,
    input  logic             wfull,
    output logic             w,
    output logic [W-1:0]     wd,
    output logic [15:0]      wcount
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t        state, state_nx;
    logic [IW-1:0] ptr, idx;
    logic          grant_ok, delay_done;

`ifdef AFIFO_ARB_STARTUP_DELAY_EN
    logic [DELAY_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (state == DELAY)
            cnt <= cnt + 1'b1;
    end
    assign delay_done = &cnt;
`else
    assign delay_done = DELAY_W > 0;
`endif

    assign grant_ok = (state == RUN) && en && !wfull;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req    (req),
        .pointer(ptr),
        .enable (grant_ok),
        .grant  (ack),
        .index  (idx)
    );

    always_comb begin
        state_nx = state;
        case (state)
            DELAY:   if (delay_done) state_nx = IDLE;
            IDLE:    if (en)         state_nx = RUN;
            RUN:     if (!en)        state_nx = PAUSE;
            PAUSE:   if (en)         state_nx = RUN;
            default:                 state_nx = DELAY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= DELAY;
            ptr    <= '0;
            w      <= 1'b0;
            wd     <= '0;
            wcount <= '0;
        end else begin
            state  <= state_nx;
            w      <= |ack;
            wcount <= wcount + 16'(w);
            if (|ack) begin
                wd  <= data[idx*W +: W];
                ptr <= (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
            end
        end
    end
endmodule
